// File: rtl/poly_noteplayer.sv
`timescale 1ns/1ps
// poly_noteplayer: NUM_VOICES-voice note player. On each sample request it
// time-multiplexes one external frequency ROM and one sine ROM across all
// voices, sums the per-voice sine samples and scales the sum by NUM_VOICES.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   load_valid/voice/note/dur   voice load (note 0 = rest)
//   beat                        1/48 s tick, decrements active voice durations
//   generate_next_sample        codec sample request (ignored while busy)
//   freq_addr / freq_data       frequency ROM port (data 1 cycle after addr)
//   sine_addr / sine_data       sine ROM port (data 1 cycle after addr)
//   sample_out                  mixed signed sample, held between updates
//   new_sample_ready            1-cycle pulse when sample_out updates
//   voice_active                per-voice active flags
//
// Optional: define NOTE_DECAY_EN to add per-voice attenuation that grows by
// one 6 dB step every 8 beats (saturating at >>>7) and is cleared on load.
module poly_noteplayer #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned VW         = 2,
    parameter int unsigned STEP_W     = 20,
    parameter int unsigned PHASE_W    = 22,
    parameter int unsigned SINE_AW    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [VW-1:0]         load_voice,
    input  logic [5:0]            load_note,
    input  logic [5:0]            load_duration,
    input  logic                  beat,
    input  logic                  generate_next_sample,
    output logic [5:0]            freq_addr,
    input  logic [STEP_W-1:0]     freq_data,
    output logic [SINE_AW-1:0]    sine_addr,
    input  logic [15:0]           sine_data,
    output logic [15:0]           sample_out,
    output logic                  new_sample_ready,
    output logic [NUM_VOICES-1:0] voice_active
);

    localparam int unsigned ACC_W = 16 + VW;

    typedef enum logic [1:0] {IDLE, ADDR, ACC, DONE} state_t;

    state_t                    state, state_n;
    logic [VW-1:0]             idx, idx_n;
    logic signed [ACC_W-1:0]   acc, acc_n;
    logic signed [ACC_W-1:0]   contrib;
    logic [15:0]               sample_n;
    logic                      ready_n;
    logic [5:0]                freq_addr_n;
    logic [SINE_AW-1:0]        sine_addr_n;

    logic [5:0]                note      [NUM_VOICES];
    logic [5:0]                remaining [NUM_VOICES];
    logic [PHASE_W-1:0]        phase     [NUM_VOICES];

`ifdef NOTE_DECAY_EN
    logic [2:0]                atten     [NUM_VOICES];
    logic [2:0]                presc     [NUM_VOICES];
    logic signed [15:0]        shaped;

    // Attenuated, sign-extended contribution of the voice in its ACC cycle
    always_comb begin
        shaped  = $signed(sine_data) >>> atten[idx];
        contrib = voice_active[idx] ? {{VW{shaped[15]}}, shaped} : '0;
    end
`else
    // Sign-extended contribution of the voice in its ACC cycle
    always_comb begin
        contrib = voice_active[idx] ? {{VW{sine_data[15]}}, sine_data} : '0;
    end
`endif

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            acc              <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            freq_addr        <= '0;
            sine_addr        <= '0;
        end else begin
            state            <= state_n;
            idx              <= idx_n;
            acc              <= acc_n;
            sample_out       <= sample_n;
            new_sample_ready <= ready_n;
            freq_addr        <= freq_addr_n;
            sine_addr        <= sine_addr_n;
        end
    end

    // Next-state logic; ROM addresses are registered on entry to ADDR so the
    // ROM data lands in the following ACC cycle. The sample is registered on
    // entry to DONE so the ready pulse is visible during DONE.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        acc_n       = acc;
        sample_n    = sample_out;
        ready_n     = 1'b0;
        freq_addr_n = freq_addr;
        sine_addr_n = sine_addr;
        case (state)
            IDLE: begin
                if (generate_next_sample) begin
                    acc_n       = '0;
                    idx_n       = '0;
                    freq_addr_n = note[0];
                    sine_addr_n = phase[0][PHASE_W-1 -: SINE_AW];
                    state_n     = ADDR;
                end
            end
            ADDR: state_n = ACC;
            ACC: begin
                acc_n = acc + contrib;
                if (idx == VW'(NUM_VOICES - 1)) begin
                    sample_n = 16'(acc_n >>> VW);
                    ready_n  = 1'b1;
                    state_n  = DONE;
                end else begin
                    idx_n       = idx + VW'(1);
                    freq_addr_n = note[idx_n];
                    sine_addr_n = phase[idx_n][PHASE_W-1 -: SINE_AW];
                    state_n     = ADDR;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Per-voice state: load has priority over beat and phase advance; a beat
    // that expires a voice clears its phase over any same-cycle advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            voice_active <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note[v]      <= '0;
                remaining[v] <= '0;
                phase[v]     <= '0;
`ifdef NOTE_DECAY_EN
                atten[v]     <= '0;
                presc[v]     <= '0;
`endif
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (load_valid && load_voice == VW'(v)) begin
                    note[v]         <= load_note;
                    remaining[v]    <= load_duration;
                    phase[v]        <= '0;
                    voice_active[v] <= (load_note != 6'd0) && (load_duration != 6'd0);
`ifdef NOTE_DECAY_EN
                    atten[v]        <= '0;
                    presc[v]        <= '0;
`endif
                end else begin
                    if (state == ACC && idx == VW'(v) && voice_active[v])
                        phase[v] <= phase[v] + PHASE_W'(freq_data);
                    if (beat && voice_active[v]) begin
                        remaining[v] <= remaining[v] - 6'd1;
                        if (remaining[v] == 6'd1) begin
                            voice_active[v] <= 1'b0;
                            phase[v]        <= '0;
                        end
`ifdef NOTE_DECAY_EN
                        presc[v] <= presc[v] + 3'd1;
                        if (presc[v] == 3'd7 && atten[v] != 3'd7)
                            atten[v] <= atten[v] + 3'd1;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_noteplayer.sv
`timescale 1ns/1ps
// Directed self-checking bench for poly_noteplayer with synchronous ROM models.
module tb_poly_noteplayer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [1:0]  load_voice;
    logic [5:0]  load_note;
    logic [5:0]  load_duration;
    logic        beat;
    logic        gns;
    logic [5:0]  freq_addr;
    logic [19:0] freq_data;
    logic [9:0]  sine_addr;
    logic [15:0] sine_data;
    logic [15:0] sample_out;
    logic        new_sample_ready;
    logic [3:0]  voice_active;

    logic [19:0] freq_tab [64];
    logic [15:0] sine_const;
    logic [9:0]  sa [4];
    int          pulses;
    int          first_k;
    int          vectors = 0;
    int          miscompares = 0;

    poly_noteplayer dut (
        .clk                  (clk),
        .reset                (reset),
        .load_valid           (load_valid),
        .load_voice           (load_voice),
        .load_note            (load_note),
        .load_duration        (load_duration),
        .beat                 (beat),
        .generate_next_sample (gns),
        .freq_addr            (freq_addr),
        .freq_data            (freq_data),
        .sine_addr            (sine_addr),
        .sine_data            (sine_data),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .voice_active         (voice_active)
    );

    always #5 clk = ~clk;

    // Registered ROMs: data follows the address by one cycle
    always @(posedge clk) begin
        freq_data <= freq_tab[freq_addr];
        sine_data <= sine_const;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v, input int n, input int d);
        load_valid    = 1'b1;
        load_voice    = 2'(v);
        load_note     = 6'(n);
        load_duration = 6'(d);
        tick();
        load_valid    = 1'b0;
    endtask

    task automatic do_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    // One request; records per-voice sine_addr in ADDR cycles and ready pulses.
    // extra_k > 0 raises a second request during cycle t+extra_k.
    task automatic req(input int extra_k);
        pulses  = 0;
        first_k = 0;
        gns     = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            gns = (k == extra_k);
            if (k % 2 == 1 && k <= 7) sa[(k - 1) / 2] = sine_addr;
            if (new_sample_ready) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        gns = 1'b0;
    endtask

    initial begin
        logic [9:0] a0_exp [3];
        a0_exp[0] = 10'd0; a0_exp[1] = 10'd0; a0_exp[2] = 10'd1;
        for (int i = 0; i < 64; i++) freq_tab[i] = '0;
        sine_const    = '0;
        reset         = 1'b1;
        load_valid    = 1'b0;
        load_voice    = '0;
        load_note     = '0;
        load_duration = '0;
        beat          = 1'b0;
        gns           = 1'b0;
        repeat (3) tick();
        check("rst_sample", 32'(sample_out), 32'h0);
        check("rst_ready", 32'(new_sample_ready), 32'h0);
        check("rst_faddr", 32'(freq_addr), 32'h0);
        check("rst_saddr", 32'(sine_addr), 32'h0);
        check("rst_active", 32'(voice_active), 32'h0);
        reset = 1'b0;
        tick();

        // Idle player: silent sample, fixed latency
        req(0);
        check("idle_sample", 32'(sample_out), 32'h0);
        check("idle_latency", 32'(first_k), 32'd9);
        check("idle_pulses", 32'(pulses), 32'd1);
        check("idle_active", 32'(voice_active), 32'h0);

        // Rest and zero-duration loads do not activate
        load(1, 0, 5);
        load(2, 5, 0);
        check("rest_inactive", 32'(voice_active), 32'h0);

        // Duration countdown; phase clears when the voice expires
        freq_tab[10] = 20'h01000;
        load(0, 10, 3);
        check("load_active", 32'(voice_active), 32'h1);
        req(0);
        req(0);
        do_beat();
        check("beat1_active", 32'(voice_active[0]), 32'h1);
        do_beat();
        check("beat2_active", 32'(voice_active[0]), 32'h1);
        req(0);
        check("phase_running", 32'(sa[0]), 32'd2);
        do_beat();
        check("beat3_active", 32'(voice_active[0]), 32'h0);
        req(0);
        check("phase_cleared", 32'(sa[0]), 32'd0);

        // Full-scale mixing without wrap
        for (int v = 0; v < 4; v++) load(v, v + 1, 40);
        check("all_active", 32'(voice_active), 32'hF);
        sine_const = 16'h7FFF;
        req(0);
        check("mix_pos_full", 32'(sample_out), 32'h7FFF);
        sine_const = 16'h8000;
        req(0);
        check("mix_neg_full", 32'(sample_out), 32'h8000);
        load(2, 0, 40);
        load(3, 0, 40);
        sine_const = 16'h7FFF;
        req(0);
        check("mix_two_pos", 32'(sample_out), 32'h3FFF);
        load(1, 0, 40);
        sine_const = 16'h8000;
        req(0);
        check("mix_one_neg", 32'(sample_out), 32'hE000);

        // Phase stepping per voice
        freq_tab[7] = 20'h00800;
        freq_tab[5] = 20'h01000;
        freq_tab[9] = 20'h00000;
        sine_const  = 16'h0000;
        load(0, 7, 40);
        load(1, 5, 40);
        load(2, 0, 40);
        load(3, 9, 40);
        for (int r = 0; r < 3; r++) begin
            req(0);
            check($sformatf("v1_addr%0d", r), 32'(sa[1]), 32'(r));
            check($sformatf("v0_addr%0d", r), 32'(sa[0]), 32'(a0_exp[r]));
            check($sformatf("v2_addr%0d", r), 32'(sa[2]), 32'd0);
            check($sformatf("v3_addr%0d", r), 32'(sa[3]), 32'd0);
        end

        // Load and beat in the same cycle: full duration retained
        load_valid    = 1'b1;
        load_voice    = 2'd2;
        load_note     = 6'd3;
        load_duration = 6'd2;
        beat          = 1'b1;
        tick();
        load_valid    = 1'b0;
        beat          = 1'b0;
        check("lb_active", 32'(voice_active[2]), 32'h1);
        do_beat();
        check("lb_beat1", 32'(voice_active[2]), 32'h1);
        do_beat();
        check("lb_beat2", 32'(voice_active[2]), 32'h0);

        // Requests while busy are dropped
        req(3);
        check("busy_pulses", 32'(pulses), 32'd1);
        check("busy_latency", 32'(first_k), 32'd9);
        req(9);
        check("done_pulses", 32'(pulses), 32'd1);

        // Reset mid-sample aborts with no pulse
        sine_const = 16'h7FFF;
        gns = 1'b1;
        tick();
        gns = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (new_sample_ready) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_sample", 32'(sample_out), 32'h0);
        check("abort_active", 32'(voice_active), 32'h0);

`ifdef NOTE_DECAY_EN
        // Attenuation steps every 8 beats; reload restores full level
        freq_tab[1] = 20'h0;
        sine_const  = 16'h4000;
        load(0, 1, 63);
        for (int b = 0; b < 16; b++) begin
            req(0);
            check($sformatf("decay_b%0d", b), 32'(sample_out), (b < 8) ? 32'h1000 : 32'h0800);
            do_beat();
        end
        load(0, 1, 63);
        req(0);
        check("decay_reload", 32'(sample_out), 32'h1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
